sdram_read_buffer: RTL and testbench

Read-return buffer and transfer sequencer between the SDRAM read engine and the Wishbone SDRAM slave's read-data path. On a start request it drives `en`/`address` to the read engine and accepts exactly `word_count` 32-bit words from its FIFO write port. It stores them in an internal FIFO and delivers them to the bus side over a first-word-fall-through valid/ready port. Backpressure reaches the read engine through `fifo_full`, asserted early enough to absorb the engine's in-flight word.

---
 rtl/sdram_read_buffer.sv | 171 +++++++++++++++++
 tb/tb_sdram_read_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_buffer.sv
`default_nettype none
// ============================================================================
// Module  : sdram_read_buffer
// Brief   : Sequences one SDRAM read transfer and buffers the returned words
//           in a first-word-fall-through FIFO for the bus-side consumer.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_read_buffer #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [21:0] start_address,
    input  logic [8:0]  word_count,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        en,
    output logic [21:0] address,
    input  logic [31:0] fifo_data,
    input  logic        fifo_wr,
    output logic        fifo_full,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [AW:0] C_DEPTH   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C_FULL_TH = (AW + 1)'(DEPTH - FULL_MARGIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [31:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [AW:0]    w_count_next;
    logic [8:0]     r_wr_cnt;
    logic [8:0]     r_rd_cnt;
    logic [8:0]     r_word_count;
    logic [21:0]    r_address;
    logic           r_overflow;
    logic           r_fifo_full;

    logic w_start_acc;
    logic w_in_window;
    logic w_storage_full;
    logic w_push;
    logic w_drop_full;
    logic w_pop;

    assign w_start_acc    = (r_state == S_IDLE) && start;
    // Words outside the transfer window are trailing engine words: ignored.
    assign w_in_window    = (r_state == S_FETCH) && (r_wr_cnt < r_word_count);
    assign w_storage_full = (r_count == C_DEPTH);
    assign w_push         = fifo_wr && w_in_window && !w_storage_full;
    assign w_drop_full    = fifo_wr && w_in_window && w_storage_full;
    assign w_pop          = out_valid && out_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (word_count == 9'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_push && ((r_wr_cnt + 9'd1) == r_word_count)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_rd_cnt == r_word_count) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fifo_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_next;
            r_fifo_full <= (w_count_next >= C_FULL_TH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_word_count <= '0;
            r_address    <= '0;
            r_overflow   <= 1'b0;
        end else if (w_start_acc) begin
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_word_count <= word_count;
            r_address    <= start_address;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_cnt <= r_wr_cnt + 9'd1;
            end
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + 9'd1;
            end
            if (w_drop_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_data;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign en        = (r_state == S_FETCH);
    assign address   = r_address;
    assign overflow  = r_overflow;
    assign fifo_full = r_fifo_full;
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_sdram_read_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_read_buffer
// Brief   : Self-checking bench: per-cycle vector table plus directed sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdram_read_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [21:0] start_address = '0;
    logic [8:0]  word_count = '0;
    logic        busy, done, overflow, en, fifo_full, out_valid;
    logic [21:0] address;
    logic [31:0] fifo_data = '0;
    logic        fifo_wr = 1'b0;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    sdram_read_buffer #(.DEPTH(16), .AW(4), .FULL_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .start(start), .start_address(start_address),
        .word_count(word_count), .busy(busy), .done(done), .overflow(overflow),
        .en(en), .address(address), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
        .fifo_full(fifo_full), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_pop_cyc = -1;
    logic [31:0] rx [$];

    typedef struct {
        logic        start;
        logic [8:0]  wc;
        logic        wr;
        logic [31:0] data;
        logic        en;
        logic        busy;
        logic        dn;
        logic        valid;
        logic [31:0] odata;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t v(logic s, logic [8:0] wc, logic w, logic [31:0] d,
                               logic e, logic b, logic dn, logic vl, logic [31:0] od);
        vec_t r;
        r.start = s; r.wc = wc; r.wr = w; r.data = d;
        r.en = e; r.busy = b; r.dn = dn; r.valid = vl; r.odata = od;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: capture a pop happening this cycle, then advance past the edge.
    task automatic step();
        if (out_valid && out_ready) begin
            rx.push_back(out_data);
            last_pop_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic begin_xfer(logic [21:0] a, logic [8:0] wc, logic rdy);
        start_address = a;
        word_count    = wc;
        out_ready     = rdy;
        start         = 1'b1;
        step();
        start         = 1'b0;
    endtask

    task automatic wait_done(int base, int budget, string name);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            step();
            n++;
        end
        chk(name, done_cnt - base, 1);
    endtask

    initial begin
        int sent;
        int first_full;
        int base;
        int errs;
        logic prev_full;
        logic cur_full;

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_en", en, 0);
        chk("rst_addr", address, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- vector table: basic transfer ----------------
        tbl[0]  = v(1, 4, 0, 0,            1, 1, 0, 0, 0);
        tbl[1]  = v(0, 4, 1, 32'hA0000001, 1, 1, 0, 1, 32'hA0000001);
        tbl[2]  = v(0, 4, 0, 0,            1, 1, 0, 0, 0);
        tbl[3]  = v(0, 4, 1, 32'hA0000002, 1, 1, 0, 1, 32'hA0000002);
        tbl[4]  = v(1, 0, 0, 0,            1, 1, 0, 0, 0);
        tbl[5]  = v(0, 4, 1, 32'hA0000003, 1, 1, 0, 1, 32'hA0000003);
        tbl[6]  = v(0, 4, 0, 0,            1, 1, 0, 0, 0);
        tbl[7]  = v(0, 4, 1, 32'hA0000004, 0, 1, 0, 1, 32'hA0000004);
        tbl[8]  = v(0, 4, 0, 0,            0, 1, 0, 0, 0);
        tbl[9]  = v(0, 4, 0, 0,            0, 1, 1, 0, 0);
        tbl[10] = v(0, 4, 0, 0,            0, 0, 0, 0, 0);
        tbl[11] = v(1, 0, 0, 0,            0, 1, 1, 0, 0);
        tbl[12] = v(0, 0, 0, 0,            0, 0, 0, 0, 0);

        out_ready = 1'b1;
        start_address = 22'h12345;
        for (int i = 0; i < 13; i++) begin
            start      = tbl[i].start;
            word_count = tbl[i].wc;
            fifo_wr    = tbl[i].wr;
            fifo_data  = tbl[i].data;
            step();
            chk($sformatf("vec%0d_en", i), en, tbl[i].en);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d_done", i), done, tbl[i].dn);
            chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].valid);
            if (tbl[i].valid)
                chk($sformatf("vec%0d_data", i), out_data, tbl[i].odata);
            chk($sformatf("vec%0d_addr", i), address, 22'h12345);
            chk($sformatf("vec%0d_ovf", i), overflow, 0);
            chk($sformatf("vec%0d_full", i), fifo_full, 0);
        end
        start = 1'b0; fifo_wr = 1'b0;

        // ---------------- backpressure with one-word lag ----------------
        rx.delete();
        begin_xfer(22'h0, 9'd20, 1'b0);
        sent = 0; first_full = -1; prev_full = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (fifo_full && first_full < 0) first_full = sent;
            fifo_wr   = en && (sent < 20) && !prev_full;
            fifo_data = 32'hB0000000 + sent;
            cur_full  = fifo_full;
            step();
            if (fifo_wr) sent++;
            prev_full = cur_full;
        end
        fifo_wr = 1'b0;
        chk("bp_full_at", first_full, 14);
        chk("bp_sent", sent, 15);
        chk("bp_count", 32'(dut.r_count), 15);
        chk("bp_ovf", overflow, 0);
        chk("bp_full", fifo_full, 1);
        base = done_cnt;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && done_cnt == base; k++) begin
            fifo_wr   = en && (sent < 20) && !prev_full;
            fifo_data = 32'hB0000000 + sent;
            cur_full  = fifo_full;
            step();
            if (fifo_wr) sent++;
            prev_full = cur_full;
        end
        fifo_wr = 1'b0;
        chk("bp_done", done_cnt - base, 1);
        chk("bp_rx_n", rx.size(), 20);
        for (int i = 0; i < rx.size() && i < 20; i++)
            chk($sformatf("bp_data%0d", i), rx[i], 32'hB0000000 + i);
        step();

        // ---------------- overflow ----------------
        rx.delete();
        begin_xfer(22'h0, 9'd20, 1'b0);
        for (int i = 0; i < 18; i++) begin
            fifo_wr = 1'b1; fifo_data = 32'hC0000000 + i;
            step();
        end
        fifo_wr = 1'b0;
        chk("ovf_count", 32'(dut.r_count), 16);
        chk("ovf_wrcnt", 32'(dut.r_wr_cnt), 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_full", fifo_full, 1);
        repeat (3) step();
        chk("ovf_sticky", overflow, 1);
        out_ready = 1'b1;
        repeat (17) step();
        chk("ovf_rx_n", rx.size(), 16);
        for (int i = 0; i < rx.size() && i < 16; i++)
            chk($sformatf("ovf_data%0d", i), rx[i], 32'hC0000000 + i);
        base = done_cnt;
        for (int i = 0; i < 4; i++) begin
            fifo_wr = 1'b1; fifo_data = 32'hE0000000 + i;
            step();
        end
        fifo_wr = 1'b0;
        wait_done(base, 20, "ovf_done");
        chk("ovf_rx_n2", rx.size(), 20);
        for (int i = 16; i < rx.size() && i < 20; i++)
            chk($sformatf("ovf_tail%0d", i), rx[i], 32'hE0000000 + (i - 16));
        step();
        begin_xfer(22'h0, 9'd0, 1'b1);
        chk("ovf_cleared", overflow, 0);
        chk("wc0_done", done, 1);
        chk("wc0_en", en, 0);
        step();
        chk("wc0_idle", busy, 0);

        // ---------------- trailing words ----------------
        rx.delete();
        base = done_cnt;
        begin_xfer(22'h00100, 9'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            fifo_wr = 1'b1; fifo_data = 32'hF0000000 + i;
            step();
        end
        fifo_wr = 1'b0;
        repeat (5) step();
        chk("trl_rx_n", rx.size(), 3);
        for (int i = 0; i < rx.size() && i < 3; i++)
            chk($sformatf("trl_data%0d", i), rx[i], 32'hF0000000 + i);
        chk("trl_ovf", overflow, 0);
        chk("trl_done_n", done_cnt - base, 1);
        chk("trl_done_lat", done_cyc - last_pop_cyc, 2);
        chk("trl_idle", busy, 0);

        // ---------------- pointer wrap, 256 words ----------------
        rx.delete();
        base = done_cnt;
        begin_xfer(22'h3FFFF, 9'd256, 1'b1);
        sent = 0;
        for (int k = 0; k < 400 && done_cnt == base; k++) begin
            fifo_wr   = en;
            fifo_data = 32'hD0000000 + sent;
            step();
            if (fifo_wr) sent++;
        end
        fifo_wr = 1'b0;
        chk("wrap_done", done_cnt - base, 1);
        chk("wrap_rx_n", rx.size(), 256);
        errs = 0;
        for (int i = 0; i < rx.size(); i++)
            if (rx[i] !== 32'hD0000000 + i) errs++;
        chk("wrap_order", errs, 0);
        step();

        // ---------------- reset mid-FETCH ----------------
        rx.delete();
        begin_xfer(22'h01234, 9'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            fifo_wr = 1'b1; fifo_data = 32'h55000000 + i;
            step();
        end
        fifo_wr = 1'b0;
        chk("mr_pre_en", en, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_en", en, 0);
        chk("mr_busy", busy, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_addr", address, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        base = done_cnt;
        begin_xfer(22'h2AAAA, 9'd1, 1'b1);
        chk("mr_new_addr", address, 22'h2AAAA);
        chk("mr_new_en", en, 1);
        fifo_wr = 1'b1; fifo_data = 32'h66666666;
        step();
        fifo_wr = 1'b0;
        wait_done(base, 10, "mr_done");
        chk("mr_rx_n", rx.size(), 1);
        if (rx.size() > 0) chk("mr_data", rx[0], 32'h66666666);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
